// File: rtl/matrix_loader_pkg.sv
// Shared configuration for the matrix loader: word/address widths, matrix size
// and the controller state encoding.
package matrix_loader_pkg;

    localparam int CFG_N         = 8;
    localparam int CFG_WORD_SIZE = 16;
    localparam int CFG_ADDRS_LEN = 7;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_WAIT    = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_DRAIN   = 3'd4
    } state_e;

    // Index width that stays legal for single-entry structures.
    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/matrix_loader_result_buffer.sv
// Result buffer: N entries of {element, QI, QF}; one write port, one async read port.
// Latency: write visible one cycle after wr_en; read is combinational. No backpressure.
// Contents clear on reset so a discarded frame leaves nothing behind.
module result_buffer #(
    parameter int N  = 8,
    parameter int W  = 24,
    parameter int IW = 3
)(
    input  logic          src_clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [IW-1:0] wr_idx,
    input  logic [W-1:0]  wr_dat,
    input  logic [IW-1:0] rd_idx,
    output logic [W-1:0]  rd_dat
);

    logic [W-1:0] mem_q [N];
    logic [W-1:0] mem_d [N];

    always_comb begin
        mem_d = mem_q;
        if (wr_en) begin
            mem_d[wr_idx] = wr_dat;
        end
    end

    always_ff @(posedge src_clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rd_dat = mem_q[rd_idx];

endmodule

// File: rtl/matrix_loader.sv
// Streams an N*N matrix plus N-vector into multiplier memory, then samples N results
// on a fixed schedule and drains them. Latency: write one cycle after accept.
// Backpressure: s_ready only in IDLE/LOAD; DRAIN stalls indefinitely on m_ready low.
module matrix_loader
    import matrix_loader_pkg::*;
#(
    parameter int N          = CFG_N,
    parameter int WORD_SIZE  = CFG_WORD_SIZE,
    parameter int ADDRS_LEN  = CFG_ADDRS_LEN,
    parameter int RES_WAIT   = 70,
    parameter int RES_STRIDE = 2
)(
    input  logic                        src_clk,
    input  logic                        rst_n,
    input  logic                        s_valid,
    output logic                        s_ready,
    input  logic [WORD_SIZE-1:0]        s_data,
    output logic                        we,
    output logic [ADDRS_LEN-1:0]        addr,
    output logic [WORD_SIZE-1:0]        data_wr,
    input  logic signed [WORD_SIZE-1:0] AB_Transpose,
    input  logic [3:0]                  QI,
    input  logic [3:0]                  QF,
    output logic                        m_valid,
    input  logic                        m_ready,
    output logic [WORD_SIZE-1:0]        m_data,
    output logic [3:0]                  m_qi,
    output logic [3:0]                  m_qf,
    output logic                        m_last,
    output logic                        busy
);

    localparam int TOTAL = N * N + N;
    localparam int CW    = idx_width(TOTAL);
    localparam int IW    = idx_width(N);
    localparam int TW    = $clog2(RES_WAIT + RES_STRIDE + 1);
    localparam int BW    = WORD_SIZE + 8;

    state_e                 state_q, state_d;
    logic                   rdy_en_q;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   we_q, we_d;
    logic [ADDRS_LEN-1:0]   addr_q, addr_d;
    logic [WORD_SIZE-1:0]   data_wr_q, data_wr_d;
    logic [TW-1:0]          tmr_q, tmr_d;
    logic [IW-1:0]          smp_q, smp_d;
    logic [IW-1:0]          rd_q, rd_d;

    logic                   accept;
    logic                   buf_wr;
    logic [BW-1:0]          buf_rd_dat;

    // s_ready is held off until the first edge after reset release.
    assign s_ready = rdy_en_q && ((state_q == ST_IDLE) || (state_q == ST_LOAD));
    assign accept  = s_valid && s_ready;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        we_d      = 1'b0;
        addr_d    = addr_q;
        data_wr_d = data_wr_q;
        tmr_d     = tmr_q;
        smp_d     = smp_q;
        rd_d      = rd_q;
        buf_wr    = 1'b0;

        case (state_q)
            ST_IDLE, ST_LOAD: begin
                if (accept) begin
                    we_d      = 1'b1;
                    addr_d    = ADDRS_LEN'(cnt_q);
                    data_wr_d = s_data;
                    if (cnt_q == CW'(TOTAL - 1)) begin
                        state_d = ST_WAIT;
                        tmr_d   = '0;
                    end else begin
                        state_d = ST_LOAD;
                        cnt_d   = cnt_q + CW'(1);
                    end
                end
            end
            ST_WAIT: begin
                if (tmr_q == TW'(RES_WAIT - 1)) begin
                    state_d = ST_CAPTURE;
                    tmr_d   = '0;
                    smp_d   = '0;
                end else begin
                    tmr_d = tmr_q + TW'(1);
                end
            end
            ST_CAPTURE: begin
                // tmr_q walks 0..RES_STRIDE-1; a sample lands on every zero.
                tmr_d = (tmr_q == TW'(RES_STRIDE - 1)) ? '0 : tmr_q + TW'(1);
                if (tmr_q == '0) begin
                    buf_wr = 1'b1;
                    if (smp_q == IW'(N - 1)) begin
                        state_d = ST_DRAIN;
                        smp_d   = '0;
                        rd_d    = '0;
                        tmr_d   = '0;
                    end else begin
                        smp_d = smp_q + IW'(1);
                    end
                end
            end
            ST_DRAIN: begin
                if (m_ready) begin
                    if (rd_q == IW'(N - 1)) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                        rd_d    = '0;
                        tmr_d   = '0;
                    end else begin
                        rd_d = rd_q + IW'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                tmr_d   = '0;
                smp_d   = '0;
                rd_d    = '0;
            end
        endcase
    end

    always_ff @(posedge src_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            rdy_en_q  <= 1'b0;
            cnt_q     <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            data_wr_q <= '0;
            tmr_q     <= '0;
            smp_q     <= '0;
            rd_q      <= '0;
        end else begin
            state_q   <= state_d;
            rdy_en_q  <= 1'b1;
            cnt_q     <= cnt_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            data_wr_q <= data_wr_d;
            tmr_q     <= tmr_d;
            smp_q     <= smp_d;
            rd_q      <= rd_d;
        end
    end

    result_buffer #(
        .N  (N),
        .W  (BW),
        .IW (IW)
    ) u_result_buffer (
        .src_clk (src_clk),
        .rst_n   (rst_n),
        .wr_en   (buf_wr),
        .wr_idx  (smp_q),
        .wr_dat  ({AB_Transpose, QI, QF}),
        .rd_idx  (rd_q),
        .rd_dat  (buf_rd_dat)
    );

    assign we      = we_q;
    assign addr    = addr_q;
    assign data_wr = data_wr_q;
    assign m_valid = (state_q == ST_DRAIN);
    assign m_last  = m_valid && (rd_q == IW'(N - 1));
    assign busy    = (state_q != ST_IDLE);
    assign m_data  = buf_rd_dat[BW-1:8];
    assign m_qi    = buf_rd_dat[7:4];
    assign m_qf    = buf_rd_dat[3:0];

endmodule

// File: tb/tb_matrix_loader.sv
// Self-checking bench for matrix_loader: table of frame scenarios against a
// cycle-indexed reference model, plus a hand-written mid-frame reset sequence.
module tb_matrix_loader;

    localparam int N     = 8;
    localparam int W     = 16;
    localparam int AW    = 7;
    localparam int RW    = 70;
    localparam int RS    = 2;
    localparam int TOTAL = N * N + N;
    localparam int TLAST = RW + (N - 1) * RS;

    logic          src_clk = 1'b0;
    logic          rst_n;
    logic          s_valid;
    logic          s_ready;
    logic [W-1:0]  s_data;
    logic          we;
    logic [AW-1:0] addr;
    logic [W-1:0]  data_wr;
    logic signed [W-1:0] ab;
    logic [3:0]    qi, qf;
    logic          m_valid, m_ready;
    logic [W-1:0]  m_data;
    logic [3:0]    m_qi, m_qf;
    logic          m_last, busy;

    always #5 src_clk = ~src_clk;

    matrix_loader #(
        .N(N), .WORD_SIZE(W), .ADDRS_LEN(AW), .RES_WAIT(RW), .RES_STRIDE(RS)
    ) dut (
        .src_clk(src_clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .we(we), .addr(addr), .data_wr(data_wr),
        .AB_Transpose(ab), .QI(qi), .QF(qf),
        .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .m_qi(m_qi), .m_qf(m_qf),
        .m_last(m_last), .busy(busy)
    );

    int checks = 0;
    int errors = 0;
    logic [31:0] last_addr_g = 0;
    logic [31:0] last_data_g = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // vmode: 0 always valid, 1 toggling, 2 random; rmode: 0 ready, 1 stall 20, 2 random
    // abmode: 0 = 0x0100+k pattern with QI=3/QF=5, 1 = random; dmode: 0 = idx+1, 1 = random
    typedef struct {
        int vmode;
        int rmode;
        int abmode;
        int dmode;
        int exp_writes;
        int exp_last_addr;
        int exp_last_mdata;
    } vec_t;

    task automatic run_frame(input vec_t v, output int dut_writes,
                             output int dut_last_addr, output int dut_last_mdata);
        logic [W-1:0]  words [TOTAL];
        logic [W+7:0]  exp_buf [N];
        logic [W-1:0]  cur_ab;
        logic [3:0]    cur_qi, cur_qf;
        int  widx = 0, t = -2, ridx = 0, cyc = 0, drain_cyc = 0, tn;
        bit  post = 0, done = 0, acc, hs, mv_exp;
        dut_writes = 0; dut_last_addr = -1; dut_last_mdata = -1;
        for (int i = 0; i < TOTAL; i++)
            words[i] = (v.dmode == 0) ? W'(i + 1) : W'($urandom);
        for (int i = 0; i < N; i++) exp_buf[i] = '0;

        while (!done && cyc < 3000) begin
            if (!post) begin
                case (v.vmode)
                    0:       s_valid = 1'b1;
                    1:       s_valid = (cyc % 2 == 0);
                    default: s_valid = 1'($urandom);
                endcase
                s_data = words[widx];
            end else begin
                s_valid = 1'($urandom);
                s_data  = W'($urandom);
            end
            mv_exp = post && !done && (t >= TLAST);
            case (v.rmode)
                0:       m_ready = 1'b1;
                1:       m_ready = (drain_cyc >= 20);
                default: m_ready = 1'($urandom);
            endcase
            tn = t + 1;
            if (v.abmode == 0 && post && tn >= RW) begin
                cur_ab = W'(16'h0100 + (tn - RW) / RS);
                cur_qi = 4'd3;
                cur_qf = 4'd5;
            end else begin
                cur_ab = W'($urandom);
                cur_qi = 4'($urandom);
                cur_qf = 4'($urandom);
            end
            ab = cur_ab; qi = cur_qi; qf = cur_qf;
            acc = s_valid && !post;
            hs  = mv_exp && m_ready;
            if (hs && ridx == N - 1) dut_last_mdata = int'(m_data);

            @(posedge src_clk); #1;
            cyc++;

            if (acc) begin
                chk("we_on_accept", 32'(we), 1);
                chk("addr_on_accept", 32'(addr), widx);
                chk("data_wr_on_accept", 32'(data_wr), 32'(words[widx]));
                last_addr_g = widx;
                last_data_g = 32'(words[widx]);
                widx++;
                if (widx == TOTAL) begin
                    post = 1;
                    t = -1;
                end
            end else begin
                chk("we_idle", 32'(we), 0);
                chk("addr_hold", 32'(addr), last_addr_g);
                chk("data_wr_hold", 32'(data_wr), last_data_g);
                if (post) begin
                    t++;
                    if (t >= RW && (t - RW) % RS == 0 && (t - RW) / RS < N)
                        exp_buf[(t - RW) / RS] = {cur_ab, cur_qi, cur_qf};
                end
            end
            if (mv_exp) drain_cyc++;
            if (hs) begin
                ridx++;
                if (ridx == N) done = 1;
            end
            if (we) begin
                dut_writes++;
                dut_last_addr = int'(addr);
            end

            chk("busy", 32'(busy), 32'(widx > 0 && !done));
            chk("s_ready", 32'(s_ready), 32'(!post || done));
            chk("m_valid", 32'(m_valid), 32'(post && !done && t >= TLAST));
            if (post && !done && t >= TLAST) begin
                chk("m_data", 32'(m_data), 32'(exp_buf[ridx][W+7:8]));
                chk("m_qi", 32'(m_qi), 32'(exp_buf[ridx][7:4]));
                chk("m_qf", 32'(m_qf), 32'(exp_buf[ridx][3:0]));
                chk("m_last", 32'(m_last), 32'(ridx == N - 1));
            end
        end
        if (!done) begin
            errors++;
            checks++;
            $display("FAIL frame_timeout: got %0d results expected %0d", ridx, N);
        end
        s_valid = 1'b0;
    endtask

    vec_t vecs [5];
    int wr_cnt, la, lm;

    initial begin
        vecs[0] = '{0, 0, 0, 0, TOTAL, TOTAL - 1, 32'h0107};
        vecs[1] = '{1, 0, 0, 1, TOTAL, TOTAL - 1, 32'h0107};
        vecs[2] = '{0, 1, 0, 1, TOTAL, TOTAL - 1, 32'h0107};
        vecs[3] = '{2, 2, 1, 1, TOTAL, TOTAL - 1, -1};
        vecs[4] = '{0, 2, 1, 1, TOTAL, TOTAL - 1, -1};

        rst_n = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
        ab = '0; qi = '0; qf = '0;
        #1;
        chk("rst_we", 32'(we), 0);
        chk("rst_addr", 32'(addr), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_s_ready", 32'(s_ready), 0);
        chk("rst_m_valid", 32'(m_valid), 0);
        #11 rst_n = 1'b1;
        @(posedge src_clk); #1;
        chk("s_ready_after_release", 32'(s_ready), 1);

        // Frames run back to back: each starts on the cycle after the last m_last handshake.
        for (int i = 0; i < 5; i++) begin
            run_frame(vecs[i], wr_cnt, la, lm);
            chk("frame_writes", 32'(wr_cnt), 32'(vecs[i].exp_writes));
            chk("frame_last_addr", 32'(la), 32'(vecs[i].exp_last_addr));
            if (vecs[i].exp_last_mdata >= 0)
                chk("frame_last_mdata", 32'(lm), 32'(vecs[i].exp_last_mdata));
        end

        // Mid-frame reset after 30 words.
        for (int i = 0; i < 30; i++) begin
            s_valid = 1'b1;
            s_data  = W'(16'h0A00 + i);
            @(posedge src_clk); #1;
            chk("pre_rst_addr", 32'(addr), i);
            chk("pre_rst_we", 32'(we), 1);
        end
        #2 rst_n = 1'b0;
        s_valid = 1'b0;
        #1;
        chk("midrst_we", 32'(we), 0);
        chk("midrst_addr", 32'(addr), 0);
        chk("midrst_data_wr", 32'(data_wr), 0);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_m_valid", 32'(m_valid), 0);
        chk("midrst_m_last", 32'(m_last), 0);
        chk("midrst_m_data", 32'({m_data, m_qi, m_qf}), 0);
        chk("midrst_s_ready", 32'(s_ready), 0);
        @(posedge src_clk); #2;
        rst_n = 1'b1;
        @(posedge src_clk); #1;
        chk("s_ready_after_midrst", 32'(s_ready), 1);
        last_addr_g = 0;
        last_data_g = 0;
        run_frame(vecs[0], wr_cnt, la, lm);
        chk("post_rst_writes", 32'(wr_cnt), TOTAL);
        chk("post_rst_last_mdata", 32'(lm), 32'h0107);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
